reversi_move_scanner: RTL

Sequential, parametrised legal-move checker for the Reversi core. Given a target square, the side to move and a board snapshot, it walks all eight directions in parallel, one square per clock, and reports per-direction validity, the bracketing endpoint and the number of discs to flip. It sits between the cursor/input controller and the board-update FSM, which consumes `end_points` and `flip_counts` to perform the flips.

---
 rtl/reversi_move_scanner.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/reversi_move_scanner.sv
// Reversi legal-move scanner.
// Walks all eight directions from a target square in parallel, one square per clock, and
// reports which directions bracket opponent discs, where each bracket ends and how many
// discs it flips.
//
// Ports:
//   clk, resetn      - clock and synchronous active-high reset
//   start            - request a scan (accepted only while idle)
//   x, y             - target column / row (0 = left / top)
//   player_black     - side to move (1 = black, 0 = white)
//   board            - 2 bits per square, square (x,y) at bit 2*(y*N+x)
//                      00/11 = empty, 01 = black, 10 = white
//   busy             - scan in progress
//   done             - one-cycle pulse, results below updated in the same cycle
//   valids           - per-direction bracket found (bit d = direction d)
//   any_valid        - OR of valids
//   end_points       - slice d = {y,x} of the bracketing own disc, 0 when invalid
//   flip_counts      - slice d = opponent discs flipped in direction d, 0 when invalid
//   total_flips      - sum of flip_counts
// Direction order: N, NE, E, SE, S, SW, W, NW (y grows downward).
module reversi_move_scanner #(
  parameter int N = 8,
  localparam int CW = $clog2(N)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [CW-1:0]    x,
  input  logic [CW-1:0]    y,
  input  logic             player_black,
  input  logic [2*N*N-1:0] board,
  output logic             busy,
  output logic             done,
  output logic [7:0]       valids,
  output logic             any_valid,
  output logic [16*CW-1:0] end_points,
  output logic [8*CW-1:0]  flip_counts,
  output logic [CW+2:0]    total_flips
);

  localparam int IW = $clog2(2 * N * N);
  // Any coordinate at or above this, including -1 seen as unsigned, is off the board.
  localparam logic [CW:0] NBound = (CW + 1)'(N);
  localparam logic [7:0] DxPos = 8'b0000_1110;
  localparam logic [7:0] DxNeg = 8'b1110_0000;
  localparam logic [7:0] DyPos = 8'b0011_1000;
  localparam logic [7:0] DyNeg = 8'b1000_0011;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  function automatic logic [CW:0] delta(input logic pos, input logic neg);
    if (pos) return (CW + 1)'(1);
    if (neg) return '1;
    return '0;
  endfunction

  function automatic logic [1:0] square(input logic [2*N*N-1:0] b, input logic [CW-1:0] sx,
                                        input logic [CW-1:0] sy);
    logic [IW-1:0] idx;
    idx = IW'((int'(sy) * N + int'(sx)) * 2);
    return b[idx +: 2];
  endfunction

  state_e           state_q, state_d;
  logic [2*N*N-1:0] board_q;
  logic             black_q;
  logic [7:0]       active_q, active_d, valid_q, valid_d;
  // Per lane: last square stepped onto (the endpoint once valid) and opponent count.
  logic [CW-1:0]    cx_q [8], cx_d [8], cy_q [8], cy_d [8], cnt_q [8], cnt_d [8];

  logic [7:0]       valids_q, valids_d;
  logic             any_valid_q, any_valid_d;
  logic [16*CW-1:0] end_points_q, end_points_d;
  logic [8*CW-1:0]  flip_counts_q, flip_counts_d;
  logic [CW+2:0]    total_flips_q, total_flips_d;

  logic [CW:0]      nx [8], ny [8];
  logic [7:0]       off, at_rim;
  logic [1:0]       sq [8];
  logic [1:0]       own_code;
  logic             latch;

  assign own_code = black_q ? 2'b01 : 2'b10;
  assign latch    = (state_q == StIdle) && start;

  // Probe the next square of every lane, plus whether the square beyond it is off-board.
  always_comb begin
    for (int d = 0; d < 8; d++) begin
      nx[d]     = {1'b0, cx_q[d]} + delta(DxPos[d], DxNeg[d]);
      ny[d]     = {1'b0, cy_q[d]} + delta(DyPos[d], DyNeg[d]);
      off[d]    = (nx[d] >= NBound) || (ny[d] >= NBound);
      at_rim[d] = ((nx[d] + delta(DxPos[d], DxNeg[d])) >= NBound) ||
                  ((ny[d] + delta(DyPos[d], DyNeg[d])) >= NBound);
      sq[d]     = square(board_q, off[d] ? '0 : nx[d][CW-1:0], off[d] ? '0 : ny[d][CW-1:0]);
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    valid_d  = valid_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          valid_d = '0;
          for (int d = 0; d < 8; d++) begin
            cx_d[d]  = x;
            cy_d[d]  = y;
            cnt_d[d] = '0;
          end
          if (^square(board, x, y)) begin
            active_d = '0;
            state_d  = StDone;
          end else begin
            active_d = '1;
            state_d  = StScan;
          end
        end
      end
      StScan: begin
        for (int d = 0; d < 8; d++) begin
          if (active_q[d]) begin
            // cnt == 0 only on the first step, so an own disc there brackets nothing.
            if (off[d] || !(^sq[d]) || (sq[d] == own_code && cnt_q[d] == '0)) begin
              active_d[d] = 1'b0;
            end else if (sq[d] == own_code) begin
              active_d[d] = 1'b0;
              valid_d[d]  = 1'b1;
              cx_d[d]     = nx[d][CW-1:0];
              cy_d[d]     = ny[d][CW-1:0];
            end else if (at_rim[d]) begin
              // Opponent disc on the rim: nothing can close the run, resolve now.
              active_d[d] = 1'b0;
            end else begin
              cnt_d[d] = cnt_q[d] + 1'b1;
              cx_d[d]  = nx[d][CW-1:0];
              cy_d[d]  = ny[d][CW-1:0];
            end
          end
        end
        if (active_d == '0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Result image, loaded on entry to StDone.
  always_comb begin
    valids_d      = valid_d;
    any_valid_d   = |valid_d;
    end_points_d  = '0;
    flip_counts_d = '0;
    total_flips_d = '0;
    for (int d = 0; d < 8; d++) begin
      if (valid_d[d]) begin
        end_points_d[d*2*CW +: 2*CW] = {cy_d[d], cx_d[d]};
        flip_counts_d[d*CW +: CW]    = cnt_d[d];
        total_flips_d                = total_flips_d + (CW + 3)'(cnt_d[d]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q       <= StIdle;
      active_q      <= '0;
      valid_q       <= '0;
      cx_q          <= '{default: '0};
      cy_q          <= '{default: '0};
      cnt_q         <= '{default: '0};
      valids_q      <= '0;
      any_valid_q   <= 1'b0;
      end_points_q  <= '0;
      flip_counts_q <= '0;
      total_flips_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      if (state_d == StDone) begin
        valids_q      <= valids_d;
        any_valid_q   <= any_valid_d;
        end_points_q  <= end_points_d;
        flip_counts_q <= flip_counts_d;
        total_flips_q <= total_flips_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      board_q <= board;
      black_q <= player_black;
    end
  end

  assign busy        = (state_q == StScan);
  assign done        = (state_q == StDone);
  assign valids      = valids_q;
  assign any_valid   = any_valid_q;
  assign end_points  = end_points_q;
  assign flip_counts = flip_counts_q;
  assign total_flips = total_flips_q;

endmodule
